// File: rtl/spu_fetch_pkg.sv
// Shared sizes and queue entry type for the SPU instruction fetch path.
package spu_fetch_pkg;
   localparam int FQ_DEPTH = 8;
   localparam int PC_W     = 8;
   localparam int INSTR_W  = 32;
   localparam int FQ_IDX_W = $clog2(FQ_DEPTH);
   localparam int FQ_CNT_W = FQ_IDX_W + 1;

   typedef struct packed {
      logic [0:INSTR_W-1] instr;
      logic [PC_W-1:0]    pc;
   } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: pushes a full pair, pops 0..2 entries from the head per cycle.
module fetch_queue
   import spu_fetch_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                push,
   input  fq_entry_t           push_entry0,
   input  fq_entry_t           push_entry1,
   input  logic [1:0]          pop_cnt,
   output fq_entry_t           head0,
   output fq_entry_t           head1,
   output logic [FQ_CNT_W-1:0] count
);
   fq_entry_t           mem_q [FQ_DEPTH];
   fq_entry_t           mem_d [FQ_DEPTH];
   logic [FQ_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [FQ_IDX_W-1:0] head_nx, tail_nx;
   logic [FQ_CNT_W-1:0] count_q, count_d;

   always_comb begin
      head_nx = head_q + FQ_IDX_W'(1);
      tail_nx = tail_q + FQ_IDX_W'(1);
      mem_d   = mem_q;
      head_d  = head_q + FQ_IDX_W'(pop_cnt);
      tail_d  = tail_q;
      count_d = count_q + (push ? FQ_CNT_W'(2) : FQ_CNT_W'(0)) - FQ_CNT_W'(pop_cnt);
      if (push) begin
         mem_d[tail_q]  = push_entry0;
         mem_d[tail_nx] = push_entry1;
         tail_d         = tail_q + FQ_IDX_W'(2);
      end
      // Flush drops everything, including a pop or push in the same cycle.
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head0 = mem_q[head_q];
   assign head1 = mem_q[head_nx];
   assign count = count_q;
endmodule

// File: rtl/instr_fetch.sv
// Dual-issue instruction fetch: pair requests into a fetch queue, registered issue of up to two.
module instr_fetch
   import spu_fetch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   output logic               imem_rd,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [0:INSTR_W-1] imem_data0,
   input  logic [0:INSTR_W-1] imem_data1,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    pc_wb,
   output logic [0:INSTR_W-1] instr0,
   output logic [0:INSTR_W-1] instr1,
   output logic [PC_W-1:0]    pc0,
   output logic [PC_W-1:0]    pc1,
   output logic               valid0,
   output logic               valid1,
   output logic               first1
);
   localparam int BUD_W = FQ_CNT_W + 1;

   logic [PC_W-1:0]     fpc_q, fpc_d, req_pc_q, req_pc_d;
   logic                epoch_q, epoch_d, inflight_q, inflight_d, tag_q, tag_d;
   logic                valid0_q, valid0_d, valid1_q, valid1_d;
   fq_entry_t           out0_q, out0_d, out1_q, out1_d;
   fq_entry_t           head0, head1, push_entry0, push_entry1;
   logic [FQ_CNT_W-1:0] fq_count;
   logic [BUD_W-1:0]    budget;
   logic                push;
   logic [1:0]          pop_cnt;

   always_comb begin
      // Reserve room for the pair already in flight plus the one requested now.
      budget      = BUD_W'(fq_count) + (inflight_q ? BUD_W'(2) : BUD_W'(0)) + BUD_W'(2);
      imem_rd     = ~reset & ~branch_taken & (budget <= BUD_W'(FQ_DEPTH));
      push        = ~reset & ~branch_taken & inflight_q & (tag_q == epoch_q);
      push_entry0 = '{instr: imem_data0, pc: req_pc_q};
      push_entry1 = '{instr: imem_data1, pc: req_pc_q + PC_W'(1)};
      pop_cnt     = 2'd0;
      if (!reset && !branch_taken && !stall)
         pop_cnt = (fq_count >= FQ_CNT_W'(2)) ? 2'd2 : fq_count[1:0];

      fpc_d      = fpc_q;
      req_pc_d   = fpc_q;
      epoch_d    = epoch_q ^ branch_taken;
      inflight_d = imem_rd;
      tag_d      = epoch_q;
      if (branch_taken)
         fpc_d = pc_wb;
      else if (imem_rd)
         fpc_d = fpc_q + PC_W'(2);

      valid0_d = valid0_q;
      valid1_d = valid1_q;
      out0_d   = out0_q;
      out1_d   = out1_q;
      if (branch_taken) begin
         valid0_d = 1'b0;
         valid1_d = 1'b0;
      end else if (!stall) begin
         valid0_d = pop_cnt != 2'd0;
         valid1_d = pop_cnt == 2'd2;
         out0_d   = head0;
         out1_d   = head1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fpc_q      <= '0;
         req_pc_q   <= '0;
         epoch_q    <= 1'b0;
         inflight_q <= 1'b0;
         tag_q      <= 1'b0;
         valid0_q   <= 1'b0;
         valid1_q   <= 1'b0;
         out0_q     <= '0;
         out1_q     <= '0;
      end else begin
         fpc_q      <= fpc_d;
         req_pc_q   <= req_pc_d;
         epoch_q    <= epoch_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         valid0_q   <= valid0_d;
         valid1_q   <= valid1_d;
         out0_q     <= out0_d;
         out1_q     <= out1_d;
      end
   end

   fetch_queue u_fetch_queue (
      .clk         (clk),
      .reset       (reset),
      .flush       (branch_taken),
      .push        (push),
      .push_entry0 (push_entry0),
      .push_entry1 (push_entry1),
      .pop_cnt     (pop_cnt),
      .head0       (head0),
      .head1       (head1),
      .count       (fq_count)
   );

   assign imem_addr = fpc_q;
   assign instr0    = out0_q.instr;
   assign instr1    = out1_q.instr;
   assign pc0       = out0_q.pc;
   assign pc1       = out1_q.pc;
   assign valid0    = valid0_q;
   assign valid1    = valid1_q;
   assign first1    = 1'b0;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural queue model plus directed fetch/stall/redirect scenarios.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        reset, imem_rd, stall, branch_taken, valid0, valid1, first1;
   logic [7:0]  imem_addr, pc_wb, pc0, pc1;
   logic [0:31] imem_data0, imem_data1, instr0, instr1;

   typedef struct packed {
      logic [0:31] instr;
      logic [7:0]  pc;
   } ent_t;

   logic [0:31] mem [256];
   int          n_tests = 0;
   int          n_fail  = 0;

   // model state
   ent_t       m_q[$];
   ent_t       m_e0, m_e1;
   logic       m_v0, m_v1, m_pend, m_pend_epoch, m_epoch;
   logic [7:0] m_fpc, m_pend_pc;

   // memory environment state
   logic       resp_v, obs_rd;
   logic [7:0] resp_addr;

   instr_fetch dut (
      .clk(clk), .reset(reset), .imem_rd(imem_rd), .imem_addr(imem_addr),
      .imem_data0(imem_data0), .imem_data1(imem_data1), .stall(stall),
      .branch_taken(branch_taken), .pc_wb(pc_wb), .instr0(instr0), .instr1(instr1),
      .pc0(pc0), .pc1(pc1), .valid0(valid0), .valid1(valid1), .first1(first1)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   task automatic model_step(input logic rst, input logic st, input logic br,
                             input logic [7:0] tgt, input logic exp_rd);
      logic [7:0] p1;
      if (rst) begin
         m_q.delete();
         m_fpc = 8'h00; m_epoch = 1'b0; m_pend = 1'b0;
         m_v0 = 1'b0; m_v1 = 1'b0; m_e0 = '0; m_e1 = '0;
      end else if (br) begin
         m_q.delete();
         m_fpc = tgt; m_epoch = ~m_epoch; m_pend = 1'b0;
         m_v0 = 1'b0; m_v1 = 1'b0;
      end else begin
         if (!st) begin
            m_v0 = m_q.size() >= 1;
            m_v1 = m_q.size() >= 2;
            if (m_v0) m_e0 = m_q.pop_front();
            if (m_v1) m_e1 = m_q.pop_front();
         end
         if (m_pend && m_pend_epoch == m_epoch) begin
            p1 = m_pend_pc + 8'd1;
            m_q.push_back('{instr: mem[m_pend_pc], pc: m_pend_pc});
            m_q.push_back('{instr: mem[p1], pc: p1});
         end
         m_pend       = exp_rd;
         m_pend_pc    = m_fpc;
         m_pend_epoch = m_epoch;
         if (exp_rd) m_fpc = m_fpc + 8'd2;
      end
   endtask

   // Called at posedge+1: drive one cycle, check at negedge, advance model on the next edge.
   task automatic cycle(input logic rst, input logic st, input logic br, input logic [7:0] tgt);
      logic       exp_rd;
      logic [7:0] a1;
      reset = rst; stall = st; branch_taken = br; pc_wb = tgt;
      if (resp_v) begin
         a1 = resp_addr + 8'd1;
         imem_data0 = mem[resp_addr];
         imem_data1 = mem[a1];
      end else begin
         imem_data0 = $urandom;
         imem_data1 = $urandom;
      end
      @(negedge clk);
      exp_rd = !rst && !br && (m_q.size() + (m_pend ? 2 : 0) + 2 <= 8);
      check_eq("valid0", 32'(valid0), 32'(m_v0));
      check_eq("valid1", 32'(valid1), 32'(m_v1));
      if (m_v0) begin
         check_eq("pc0", 32'(pc0), 32'(m_e0.pc));
         check_eq("instr0", instr0, m_e0.instr);
      end
      if (m_v1) begin
         check_eq("pc1", 32'(pc1), 32'(m_e1.pc));
         check_eq("instr1", instr1, m_e1.instr);
      end
      check_eq("imem_rd", 32'(imem_rd), 32'(exp_rd));
      if (exp_rd) check_eq("imem_addr", 32'(imem_addr), 32'(m_fpc));
      check_eq("first1", 32'(first1), 32'd0);
      obs_rd    = imem_rd;
      resp_v    = imem_rd;
      resp_addr = imem_addr;
      @(posedge clk);
      model_step(rst, st, br, tgt, exp_rd);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid0"}, 32'(valid0), 32'd0);
      check_eq({tag, "_valid1"}, 32'(valid1), 32'd0);
      check_eq({tag, "_pc0"}, 32'(pc0), 32'd0);
      check_eq({tag, "_pc1"}, 32'(pc1), 32'd0);
      check_eq({tag, "_instr0"}, instr0, 32'd0);
      check_eq({tag, "_instr1"}, instr1, 32'd0);
      check_eq({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
      check_eq({tag, "_first1"}, 32'(first1), 32'd0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; pc_wb = 8'h00;
      imem_data0 = '0; imem_data1 = '0; resp_v = 1'b0; resp_addr = 8'h00; obs_rd = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 32'(i);
      repeat (2) @(posedge clk);
      #1;
      model_step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check_reset_outputs("reset");
      cycle(1'b1, 1'b0, 1'b0, 8'h00);

      // free-running stream from address 0, word[n] = n
      for (int i = 0; i < 12; i++) begin
         if (i == 3) begin
            check_eq("first_pair_pc0", 32'(pc0), 32'h00);
            check_eq("first_pair_pc1", 32'(pc1), 32'h01);
            check_eq("first_pair_v1", 32'(valid1), 32'd1);
         end
         if (i == 4) begin
            check_eq("second_pair_pc0", 32'(pc0), 32'h02);
            check_eq("second_pair_pc1", 32'(pc1), 32'h03);
         end
         cycle(1'b0, 1'b0, 1'b0, 8'h00);
      end

      // long stall fills the queue and throttles requests
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("stall_full_rd", 32'(obs_rd), 32'd0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // redirect with a response in flight
      cycle(1'b0, 1'b0, 1'b1, 8'h40);
      check_eq("redir40_v0_a", 32'(valid0), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("redir40_v0_b", 32'(valid0), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("redir40_pc0", 32'(pc0), 32'h40);
      check_eq("redir40_pc1", 32'(pc1), 32'h41);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // redirect to the top of the address space
      cycle(1'b0, 1'b0, 1'b1, 8'hFF);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("wrap_pc0", 32'(pc0), 32'hFF);
      check_eq("wrap_pc1", 32'(pc1), 32'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("wrap_next_pc0", 32'(pc0), 32'h01);
      check_eq("wrap_next_pc1", 32'(pc1), 32'h02);

      // odd target, redirect together with stall
      cycle(1'b0, 1'b1, 1'b1, 8'h05);
      check_eq("br_stall_v0", 32'(valid0), 32'd0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // reset in the middle of a stalled, partly full stream; new memory image
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      check_reset_outputs("midreset");

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 3),
               1'($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
